// File: rtl/alu_sequencer_pkg.sv
// Shared types, opcodes and command decode for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic {StIdle, StExec} state_e;

    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CAS = 3'b111;

    // Widest address field supported by the decoder (NREG up to 256).
    localparam int unsigned MaxAw   = 8;
    localparam int unsigned MaxCmdW = 3 + 3 * MaxAw;

    typedef struct packed {
        logic [2:0]       op;
        logic [MaxAw-1:0] a1;
        logic [MaxAw-1:0] a2;
        logic [MaxAw-1:0] a3;
    } cmd_fields_t;

    // Splits {op, a1, a2, a3} for an address width of aw bits.
    function automatic cmd_fields_t decode_cmd(input logic [MaxCmdW-1:0] cmd,
                                               input int unsigned aw);
        logic [MaxCmdW-1:0] mask;
        cmd_fields_t        res;
        mask   = (MaxCmdW'(1) << aw) - MaxCmdW'(1);
        res.a3 = MaxAw'(cmd & mask);
        res.a2 = MaxAw'((cmd >> aw) & mask);
        res.a1 = MaxAw'((cmd >> (2 * aw)) & mask);
        res.op = 3'((cmd >> (3 * aw)) & MaxCmdW'(7));
        return res;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command handshake, ALU bus, status and debug signals of the ALU sequencer.
interface alu_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 8
);
    localparam int unsigned AW = $clog2(NREG);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3+3*AW-1:0] command;
    logic [2:0]        alu_op_code;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] y;
    logic              O;
    logic              C;
    logic              Z;
    logic              N;
    logic [3:0]        flags;
    logic              done;
    logic              cas_ok;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  cmd_valid, command, y, O, C, Z, N, dbg_addr,
        output cmd_ready, alu_op_code, data_a, data_b, flags, done, cas_ok, dbg_data
    );

    modport master (
        output cmd_valid, command, y, O, C, Z, N, dbg_addr,
        input  cmd_ready, alu_op_code, data_a, data_b, flags, done, cas_ok, dbg_data
    );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// NREG x DATA_W register file: two write ports (port 1 wins), three reads, debug read.
module alu_sequencer_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 8,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we0_i,
    input  logic [AW-1:0]     waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [AW-1:0]     raddr0_i,
    input  logic [AW-1:0]     raddr1_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we0_i) regs_d[waddr0_i] = wdata0_i;
        if (we1_i) regs_d[waddr1_i] = wdata1_i;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= rst_i ? '0 : regs_d[i];
        end
    end

    assign rdata0_o   = regs_q[raddr0_i];
    assign rdata1_o   = regs_q[raddr1_i];
    assign rdata2_o   = regs_q[raddr2_i];
    assign dbg_data_o = regs_q[dbg_addr_i];
endmodule

// File: rtl/alu_sequencer.sv
// Register-file controller: decodes commands, drives the external ALU, writes results
// back, and optionally executes compare-and-swap on opcode 3'b111.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 8,
    parameter bit          CAS_EN = 1'b1
) (
    input logic             clk,
    input logic             reset,
    alu_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d, cas_ok_q, cas_ok_d, is_cas_q, is_cas_d;
    logic [AW-1:0]     a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;

    cmd_fields_t       f;
    logic              unused_cmd;
    logic [AW-1:0]     cmd_a1, cmd_a2, cmd_a3;
    logic              cmd_cas;

    logic              we0, we1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DATA_W-1:0] wdata0, wdata1, rd0, rd1, rd2;

    assign f          = decode_cmd(MaxCmdW'(bus.command), AW);
    assign unused_cmd = ^f;
    assign cmd_a1     = f.a1[AW-1:0];
    assign cmd_a2     = f.a2[AW-1:0];
    assign cmd_a3     = f.a3[AW-1:0];
    assign cmd_cas    = CAS_EN && (f.op == OP_CAS);

    always_comb begin
        state_d  = state_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        op_d     = op_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        cas_ok_d = cas_ok_q;
        is_cas_d = is_cas_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        a3_d     = a3_q;
        we0      = 1'b0;
        we1      = 1'b0;
        waddr0   = '0;
        waddr1   = '0;
        wdata0   = '0;
        wdata1   = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d  = StExec;
                    data_a_d = rd0;
                    data_b_d = rd1;
                    op_d     = cmd_cas ? OP_SUB : f.op;
                    is_cas_d = cmd_cas;
                    a1_d     = cmd_a1;
                    a2_d     = cmd_a2;
                    a3_d     = cmd_a3;
                end
            end
            StExec: begin
                state_d = StIdle;
                flags_d = {bus.O, bus.C, bus.Z, bus.N};
                done_d  = 1'b1;
                if (is_cas_q) begin
                    // Status goes through port 1 so it overrides a swap into R[NREG-1].
                    we0      = bus.Z;
                    waddr0   = a1_q;
                    wdata0   = rd2;
                    we1      = 1'b1;
                    waddr1   = AW'(NREG - 1);
                    wdata1   = DATA_W'(bus.Z);
                    cas_ok_d = bus.Z;
                end else begin
                    we0    = 1'b1;
                    waddr0 = a3_q;
                    wdata0 = bus.y;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            data_a_q <= '0;
            data_b_q <= '0;
            op_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            cas_ok_q <= 1'b0;
            is_cas_q <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
            a3_q     <= '0;
        end else begin
            state_q  <= state_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            op_q     <= op_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            cas_ok_q <= cas_ok_d;
            is_cas_q <= is_cas_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            a3_q     <= a3_d;
        end
    end

    alu_sequencer_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk_i      (clk),
        .rst_i      (reset),
        .we0_i      (we0),
        .waddr0_i   (waddr0),
        .wdata0_i   (wdata0),
        .we1_i      (we1),
        .waddr1_i   (waddr1),
        .wdata1_i   (wdata1),
        .raddr0_i   (cmd_a1),
        .raddr1_i   (cmd_cas ? cmd_a3 : cmd_a2),
        .raddr2_i   (a2_q),
        .rdata0_o   (rd0),
        .rdata1_o   (rd1),
        .rdata2_o   (rd2),
        .dbg_addr_i (bus.dbg_addr),
        .dbg_data_o (bus.dbg_data)
    );

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.alu_op_code = op_q;
    assign bus.data_a      = data_a_q;
    assign bus.data_b      = data_b_q;
    assign bus.flags       = flags_q;
    assign bus.done        = done_q;
    assign bus.cas_ok      = cas_ok_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Drives a CAS-enabled and a CAS-disabled sequencer with the same commands and checks
// both against a behavioural register-file model through an operand scoreboard.
module tb_alu_sequencer;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic [2:0]    c_op = '0;
    logic [AW-1:0] c_a1 = '0, c_a2 = '0, c_a3 = '0;
    logic [AW-1:0] dbg_addr = '0;

    alu_sequencer_if #(.DATA_W(DW), .NREG(NR)) bus0 ();
    alu_sequencer_if #(.DATA_W(DW), .NREG(NR)) bus1 ();

    alu_sequencer #(.DATA_W(DW), .NREG(NR), .CAS_EN(1'b1)) u_cas (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    alu_sequencer #(.DATA_W(DW), .NREG(NR), .CAS_EN(1'b0)) u_nocas (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    // Behavioural ALU: {O, C, Z, N, y}
    function automatic logic [DW+3:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW:0] w;
        logic [DW-1:0] y;
        logic o, c;
        o = 1'b0; c = 1'b0; w = '0; y = '0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b}; y = w[DW-1:0]; c = w[DW];
                o = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b}; y = w[DW-1:0]; c = w[DW];
                o = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: begin y = a << 1; c = a[DW-1]; end
            3'd6: begin w = {1'b0, a} + (DW+1)'(1); y = w[DW-1:0]; c = w[DW]; end
            default: y = ~(a | b);
        endcase
        return {o, c, (y == '0), y[DW-1], y};
    endfunction

    assign bus0.cmd_valid = cmd_valid;
    assign bus1.cmd_valid = cmd_valid;
    assign bus0.command   = {c_op, c_a1, c_a2, c_a3};
    assign bus1.command   = {c_op, c_a1, c_a2, c_a3};
    assign bus0.dbg_addr  = dbg_addr;
    assign bus1.dbg_addr  = dbg_addr;
    assign {bus0.O, bus0.C, bus0.Z, bus0.N, bus0.y} =
        alu_f(bus0.alu_op_code, bus0.data_a, bus0.data_b);
    assign {bus1.O, bus1.C, bus1.Z, bus1.N, bus1.y} =
        alu_f(bus1.alu_op_code, bus1.data_a, bus1.data_b);

    // Model: committed (rm/fm/cm) and pending-after-write-back (rp/fp/cp) state per DUT.
    logic [DW-1:0] rm [2][NR];
    logic [DW-1:0] rp [2][NR];
    logic [3:0]    fm [2];
    logic [3:0]    fp [2];
    logic          cm [2];
    logic          cp [2];
    bit busy = 0, exp_done = 0, mon_en = 0, accepted = 0;

    typedef struct packed {
        logic [DW-1:0] a0; logic [DW-1:0] b0; logic [2:0] op0;
        logic [DW-1:0] a1; logic [DW-1:0] b1; logic [2:0] op1;
    } opx_t;
    opx_t opq[$];

    int unsigned n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_accept();
        opx_t e;
        logic [DW+3:0] r;
        logic [DW-1:0] ea, eb;
        logic [2:0] eop;
        bit cas;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            cas = (c_op == 3'd7) && (k == 0);
            ea  = rm[k][c_a1];
            eb  = cas ? rm[k][c_a3] : rm[k][c_a2];
            eop = cas ? 3'd1 : c_op;
            r   = alu_f(eop, ea, eb);
            for (int i = 0; i < NR; i++) rp[k][i] = rm[k][i];
            fp[k] = r[DW+3:DW];
            cp[k] = cm[k];
            if (cas) begin
                if (r[DW+1]) rp[k][c_a1] = rm[k][c_a2];
                rp[k][NR-1] = DW'(r[DW+1]);
                cp[k] = r[DW+1];
            end else begin
                rp[k][c_a3] = r[DW-1:0];
            end
            if (k == 0) begin e.a0 = ea; e.b0 = eb; e.op0 = eop; end
            else begin e.a1 = ea; e.b1 = eb; e.op1 = eop; end
        end
        opq.push_back(e);
    endtask

    // One clock edge: advance the model, then return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        accepted = 0;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NR; i++) rm[k][i] = '0;
                fm[k] = '0;
                cm[k] = 1'b0;
            end
            busy = 0; exp_done = 0;
            opq.delete();
        end else if (busy) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NR; i++) rm[k][i] = rp[k][i];
                fm[k] = fp[k];
                cm[k] = cp[k];
            end
            busy = 0; exp_done = 1;
        end else begin
            exp_done = 0;
            if (cmd_valid) begin
                model_accept();
                busy = 1; accepted = 1;
            end
        end
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3);
        int n;
        n = 0;
        c_op = op; c_a1 = a1; c_a2 = a2; c_a3 = a3; cmd_valid = 1'b1;
        do begin tick(); n++; end while (!accepted && n < 8);
        chk("send_accept_within_bound", 64'(accepted), 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] a3);
        send(op, a1, a2, a3);
        tick();
    endtask

    // Builds a small constant in R[addr] from clear, shift-left and increment steps.
    task automatic set_reg(input logic [AW-1:0] addr, input logic [4:0] val);
        issue(3'd4, addr, addr, addr);
        for (int b = 4; b >= 0; b--) begin
            issue(3'd5, addr, addr, addr);
            if (val[b]) issue(3'd6, addr, addr, addr);
        end
    endtask

    // Monitor: handshake, done, status, scoreboard operands and a full register sweep.
    initial begin
        opx_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("cmd_ready_cas", 64'(bus0.cmd_ready), 64'(!busy));
                chk("cmd_ready_nocas", 64'(bus1.cmd_ready), 64'(!busy));
                chk("done_cas", 64'(bus0.done), 64'(exp_done));
                chk("done_nocas", 64'(bus1.done), 64'(exp_done));
                chk("flags_cas", 64'(bus0.flags), 64'(fm[0]));
                chk("flags_nocas", 64'(bus1.flags), 64'(fm[1]));
                chk("cas_ok_cas", 64'(bus0.cas_ok), 64'(cm[0]));
                chk("cas_ok_nocas", 64'(bus1.cas_ok), 64'(cm[1]));
                if (busy) begin
                    chk("opq_nonempty", 64'(opq.size() != 0), 64'd1);
                    if (opq.size() != 0) begin
                        e = opq.pop_front();
                        chk("data_a_cas", 64'(bus0.data_a), 64'(e.a0));
                        chk("data_b_cas", 64'(bus0.data_b), 64'(e.b0));
                        chk("op_cas", 64'(bus0.alu_op_code), 64'(e.op0));
                        chk("data_a_nocas", 64'(bus1.data_a), 64'(e.a1));
                        chk("data_b_nocas", 64'(bus1.data_b), 64'(e.b1));
                        chk("op_nocas", 64'(bus1.alu_op_code), 64'(e.op1));
                    end
                end
                for (int i = 0; i < NR; i++) begin
                    dbg_addr = AW'(i);
                    #1;
                    chk($sformatf("reg_cas_R%0d", i), 64'(bus0.dbg_data), 64'(rm[0][i]));
                    chk($sformatf("reg_nocas_R%0d", i), 64'(bus1.dbg_data), 64'(rm[1][i]));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mon_en = 1;

        // Write path: R1=5, R2=7, ADD into R3.
        set_reg(3'd1, 5'd5);
        set_reg(3'd2, 5'd7);
        send(3'd0, 3'd1, 3'd2, 3'd3);
        chk("add_data_a", 64'(bus0.data_a), 64'd5);
        chk("add_data_b", 64'(bus0.data_b), 64'd7);
        chk("add_op", 64'(bus0.alu_op_code), 64'd0);
        tick();
        chk("add_done", 64'(bus0.done), 64'd1);

        // CAS match: R1=9, R2=4, R3=9.
        set_reg(3'd1, 5'd9);
        set_reg(3'd2, 5'd4);
        set_reg(3'd3, 5'd9);
        send(3'd7, 3'd1, 3'd2, 3'd3);
        chk("cas_match_op", 64'(bus0.alu_op_code), 64'd1);
        chk("nocas_op7", 64'(bus1.alu_op_code), 64'd7);
        tick();
        chk("cas_match_ok", 64'(bus0.cas_ok), 64'd1);
        chk("nocas_cas_ok", 64'(bus1.cas_ok), 64'd0);

        // CAS miss: R1=9, R3=8.
        set_reg(3'd1, 5'd9);
        set_reg(3'd3, 5'd8);
        send(3'd7, 3'd1, 3'd2, 3'd3);
        tick();
        chk("cas_miss_ok", 64'(bus0.cas_ok), 64'd0);
        chk("cas_miss_done", 64'(bus0.done), 64'd1);

        // CAS hit with a1 = NREG-1: status must override the swapped value.
        set_reg(3'd5, 5'd0);
        issue(3'd7, 3'd7, 3'd2, 3'd5);
        chk("cas_r7_ok", 64'(bus0.cas_ok), 64'd1);

        // Handshake: valid held high, command changed during EXEC.
        cmd_valid = 1'b1;
        c_op = 3'd0; c_a1 = 3'd1; c_a2 = 3'd2; c_a3 = 3'd4;
        tick();
        chk("hs_busy_in_exec", 64'(bus0.cmd_ready), 64'd0);
        c_op = 3'd4; c_a1 = 3'd5; c_a2 = 3'd5; c_a3 = 3'd5;
        tick();
        c_op = 3'd3; c_a1 = 3'd1; c_a2 = 3'd3; c_a3 = 3'd6;
        tick();
        chk("hs_second_data_a", 64'(bus0.data_a), 64'd9);
        chk("hs_second_data_b", 64'(bus0.data_b), 64'd8);
        chk("hs_second_op", 64'(bus0.alu_op_code), 64'd3);
        cmd_valid = 1'b0;
        tick();

        // Reset while a write to R3 is pending.
        send(3'd0, 3'd1, 3'd2, 3'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_exec_ready", 64'(bus0.cmd_ready), 64'd1);
        chk("rst_exec_no_done", 64'(bus0.done), 64'd0);
        tick();
        chk("rst_exec_no_done_late", 64'(bus0.done), 64'd0);

        // Random traffic.
        repeat (400) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            c_op = 3'($urandom_range(0, 7));
            c_a1 = AW'($urandom_range(0, NR - 1));
            c_a2 = AW'($urandom_range(0, NR - 1));
            c_a3 = AW'($urandom_range(0, NR - 1));
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("opq_drained", 64'(opq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
